// File: rtl/snes_pad_responder_pkg.sv
// Shared constants, types and helpers for the SNES pad responder.
package snes_pad_responder_pkg;

  localparam int unsigned SNES_FRAME_BITS = 16;
  localparam int unsigned SNES_BTN_BITS   = 12;
  localparam int unsigned BIT_IDX_W       = 5;

  // Button positions in the codebase word (and on the wire, LSB first).
  localparam int unsigned BTN_B      = 0;
  localparam int unsigned BTN_Y      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DN     = 5;
  localparam int unsigned BTN_LT     = 6;
  localparam int unsigned BTN_RT     = 7;
  localparam int unsigned BTN_A      = 8;
  localparam int unsigned BTN_X      = 9;
  localparam int unsigned BTN_L      = 10;
  localparam int unsigned BTN_R      = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } resp_state_e;

  typedef logic [SNES_FRAME_BITS-1:0] snes_frame_t;

  // Build the 16-bit frame; the four ID bits stay 0 (wire high).
  function automatic snes_frame_t make_frame(input logic [SNES_BTN_BITS-1:0] btn);
    snes_frame_t f;
    f             = '0;
    f[BTN_B]      = btn[BTN_B];
    f[BTN_Y]      = btn[BTN_Y];
    f[BTN_SELECT] = btn[BTN_SELECT];
    f[BTN_START]  = btn[BTN_START];
    f[BTN_UP]     = btn[BTN_UP];
    f[BTN_DN]     = btn[BTN_DN];
    f[BTN_LT]     = btn[BTN_LT];
    f[BTN_RT]     = btn[BTN_RT];
    f[BTN_A]      = btn[BTN_A];
    f[BTN_X]      = btn[BTN_X];
    f[BTN_L]      = btn[BTN_L];
    f[BTN_R]      = btn[BTN_R];
    return f;
  endfunction

  // Active-low wire level for a bit index; past the frame a real pad drives 0.
  function automatic logic wire_bit(input snes_frame_t f, input logic [BIT_IDX_W-1:0] idx);
    if (idx < BIT_IDX_W'(SNES_FRAME_BITS)) begin
      return ~f[idx[3:0]];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/snes_pad_responder_if.sv
// Three-pin SNES pad link: host drives strobe/clock, device returns data.
interface snes_pad_responder_if;
  logic joy_strb;
  logic joy_clk;
  logic joy_data;

  modport master (output joy_strb, output joy_clk, input joy_data);
  modport slave  (input joy_strb, input joy_clk, output joy_data);
endinterface

// File: rtl/snes_pad_responder_sync_filter.sv
// 2-FF synchronizer followed by a stability filter with edge pulses.
module snes_pad_responder_sync_filter #(
  parameter int unsigned FILT_LEN  = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_level;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
    end
  end

  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign w_level = r_sync;
    end else begin : g_filt
      localparam int unsigned FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
      logic [FCNT_W-1:0] r_cnt;
      logic              r_level;

      // Accept a new level only after FILT_LEN consecutive differing samples.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          r_cnt   <= '0;
          r_level <= RESET_VAL;
        end else if (r_sync == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == FCNT_W'(FILT_LEN - 1)) begin
          r_cnt   <= '0;
          r_level <= r_sync;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_level = r_level;
    end
  endgenerate

  // Remember the previous filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_prev <= RESET_VAL;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/snes_pad_responder.sv
// SNES gamepad device end: latches buttons on strobe, shifts them out active-low.
module snes_pad_responder
  import snes_pad_responder_pkg::*;
#(
  parameter int unsigned FILT_LEN = 2,
  parameter int unsigned TIMEOUT  = 1_073_850,
  parameter int unsigned CNT_W    = 21
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [SNES_BTN_BITS-1:0] buttons,
  snes_pad_responder_if.slave      pad,
  output logic                     polled,
  output logic [BIT_IDX_W-1:0]     bit_idx,
  output logic                     connected
);

  resp_state_e              r_state;
  logic [SNES_BTN_BITS-1:0] r_shadow;
  logic [BIT_IDX_W-1:0]     r_bit_idx;
  logic                     r_polled;
  logic                     r_joy_data;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_connected;
  logic [CNT_W-1:0]         w_cnt_nxt;

  logic w_strb_lvl;
  logic w_strb_rise;
  logic w_strb_fall;
  logic w_clk_lvl;
  logic w_clk_rise;
  logic w_clk_fall;
  logic w_unused;

  snes_pad_responder_sync_filter #(
    .FILT_LEN  (FILT_LEN),
    .RESET_VAL (1'b0)
  ) u_strb_filt (
    .clk     (clk),
    .resetn  (resetn),
    .i_pin   (pad.joy_strb),
    .o_level (w_strb_lvl),
    .o_rise  (w_strb_rise),
    .o_fall  (w_strb_fall)
  );

  snes_pad_responder_sync_filter #(
    .FILT_LEN  (FILT_LEN),
    .RESET_VAL (1'b1)
  ) u_clk_filt (
    .clk     (clk),
    .resetn  (resetn),
    .i_pin   (pad.joy_clk),
    .o_level (w_clk_lvl),
    .o_rise  (w_clk_rise),
    .o_fall  (w_clk_fall)
  );

  // Strobe rise is implied by the level, and clock falls never shift.
  assign w_unused = &{1'b0, w_strb_rise, w_clk_lvl, w_clk_fall};

  // Frame FSM: strobe high reloads, strobe fall starts shifting, clock rises advance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_shadow   <= '0;
      r_bit_idx  <= '0;
      r_polled   <= 1'b0;
      r_joy_data <= 1'b1;
    end else begin
      r_polled <= 1'b0;
      if (w_strb_lvl) begin
        r_state   <= ST_LOAD;
        r_shadow  <= buttons;
        r_bit_idx <= '0;
      end else if (w_strb_fall) begin
        r_state   <= ST_SHIFT;
        r_bit_idx <= '0;
        r_polled  <= 1'b1;
      end else if ((r_state == ST_SHIFT) && w_clk_rise &&
                   (r_bit_idx < BIT_IDX_W'(SNES_FRAME_BITS))) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      r_joy_data <= (r_state == ST_IDLE) ? 1'b1 : wire_bit(make_frame(r_shadow), r_bit_idx);
    end
  end

  // Time since last poll, saturating so the link reads as lost.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_strb_fall) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != CNT_W'(TIMEOUT)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Connection watchdog registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt       <= CNT_W'(TIMEOUT);
      r_connected <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_connected <= (w_cnt_nxt < CNT_W'(TIMEOUT));
    end
  end

  assign pad.joy_data = r_joy_data;
  assign polled       = r_polled;
  assign bit_idx      = r_bit_idx;
  assign connected    = r_connected;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Self-checking bench for snes_pad_responder acting as an emulated host.
module tb_snes_pad_responder;

  localparam int unsigned TIMEOUT = 1000;

  logic        clk;
  logic        resetn;
  logic [11:0] buttons;
  logic        polled;
  logic [4:0]  bit_idx;
  logic        connected;

  snes_pad_responder_if pad();

  snes_pad_responder #(
    .FILT_LEN (2),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (21)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .buttons   (buttons),
    .pad       (pad),
    .polled    (polled),
    .bit_idx   (bit_idx),
    .connected (connected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int cyc;
  int npoll;
  int poll_cyc;

  // Expected wire level after k host clocks, from the pad protocol rules.
  function automatic logic exp_wire(input logic [11:0] btn, input int k);
    int b;
    b = int'(btn);
    if (k >= 16) return 1'b0;
    if (k >= 12) return 1'b1;
    return (((b >> k) % 2) == 0);
  endfunction

  function automatic int exp_idx(input int k);
    return (k > 16) ? 16 : k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (polled === 1'b1) begin
      npoll++;
      poll_cyc = cyc;
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One host frame: strobe, then nclk clock pulses, sampling after each rise.
  task automatic run_frame(input logic [11:0] btn, input int half, input int nclk,
                           input int chg_at, input logic [11:0] chg_val, input int abort_at);
    int p0;
    buttons      = btn;
    pad.joy_clk  = 1'b1;
    pad.joy_strb = 1'b1;
    wait_n(2 * half);
    p0 = npoll;
    pad.joy_strb = 1'b0;
    wait_n(half);
    chk("poll_once", npoll - p0, 1);
    chk("conn_after_poll", 32'(connected), 1);
    chk("idx_start", 32'(bit_idx), 0);
    chk("bit0", 32'(pad.joy_data), 32'(exp_wire(btn, 0)));
    for (int k = 1; k <= nclk; k++) begin
      pad.joy_clk = 1'b0;
      wait_n(half);
      pad.joy_clk = 1'b1;
      wait_n(half);
      chk("idx", 32'(bit_idx), exp_idx(k));
      chk("data", 32'(pad.joy_data), 32'(exp_wire(btn, k)));
      if (k == chg_at) buttons = chg_val;
      if (k == abort_at) begin
        pad.joy_strb = 1'b1;
        wait_n(half);
        chk("abort_idx", 32'(bit_idx), 0);
        chk("abort_data", 32'(pad.joy_data), 32'(exp_wire(buttons, 0)));
        return;
      end
    end
    chk("poll_total", npoll - p0, 1);
  endtask

  initial begin
    logic [11:0] rb;
    int n;
    total = 0; bad = 0; cyc = 0; npoll = 0; poll_cyc = 0;
    resetn = 1'b0;
    buttons = '0;
    pad.joy_strb = 1'b0;
    pad.joy_clk  = 1'b1;
    wait_n(5);
    resetn = 1'b1;
    wait_n(100);
    chk("rst_data", 32'(pad.joy_data), 1);
    chk("rst_idx", 32'(bit_idx), 0);
    chk("rst_polls", npoll, 0);
    chk("rst_conn", 32'(connected), 0);

    run_frame(12'h001, 129, 16, -1, 12'h000, -1);
    run_frame(12'hA5A, 129, 17, -1, 12'h000, -1);
    run_frame(12'h000, 40, 16, 5, 12'hFFF, -1);
    run_frame(12'($urandom), 30, 16, -1, 12'h000, 7);
    run_frame(12'h001, 30, 16, -1, 12'h000, -1);

    // Short clock glitch must be filtered; a 3-cycle pulse must count.
    rb = 12'($urandom);
    run_frame(rb, 20, 3, -1, 12'h000, -1);
    tick();
    pad.joy_clk = 1'b0;
    tick();
    pad.joy_clk = 1'b1;
    wait_n(20);
    chk("glitch_idx", 32'(bit_idx), 3);
    chk("glitch_data", 32'(pad.joy_data), 32'(exp_wire(rb, 3)));
    pad.joy_clk = 1'b0;
    wait_n(3);
    pad.joy_clk = 1'b1;
    wait_n(20);
    chk("pulse3_idx", 32'(bit_idx), 4);
    chk("pulse3_data", 32'(pad.joy_data), 32'(exp_wire(rb, 4)));

    // Clock activity under strobe, then strobe fall coinciding with clock rise.
    rb = 12'($urandom);
    buttons = rb;
    pad.joy_strb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pad.joy_clk = 1'b0;
      wait_n(10);
      pad.joy_clk = 1'b1;
      wait_n(10);
    end
    pad.joy_clk = 1'b0;
    wait_n(20);
    n = npoll;
    pad.joy_strb = 1'b0;
    pad.joy_clk  = 1'b1;
    wait_n(20);
    chk("simul_idx", 32'(bit_idx), 0);
    chk("simul_data", 32'(pad.joy_data), 32'(exp_wire(rb, 0)));
    chk("simul_poll", npoll - n, 1);
    pad.joy_clk = 1'b0;
    wait_n(20);
    pad.joy_clk = 1'b1;
    wait_n(20);
    chk("simul_next_idx", 32'(bit_idx), 1);
    chk("simul_next_data", 32'(pad.joy_data), 32'(exp_wire(rb, 1)));

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      run_frame(12'($urandom), int'($urandom_range(10, 40)), int'($urandom_range(12, 18)),
                -1, 12'h000, -1);
    end

    // Reset in mid-frame with the clock line held low.
    run_frame(12'hFFF, 20, 5, -1, 12'h000, -1);
    pad.joy_clk = 1'b0;
    resetn = 1'b0;
    tick();
    chk("rstm_idx", 32'(bit_idx), 0);
    chk("rstm_data", 32'(pad.joy_data), 1);
    chk("rstm_conn", 32'(connected), 0);
    chk("rstm_polled", 32'(polled), 0);
    wait_n(3);
    resetn = 1'b1;
    wait_n(10);
    pad.joy_clk = 1'b1;
    wait_n(10);
    chk("rstm_after_idx", 32'(bit_idx), 0);
    chk("rstm_after_data", 32'(pad.joy_data), 1);

    // Watchdog: poll from disconnected, then time out exactly TIMEOUT after it.
    for (int r = 0; r < 2; r++) begin
      chk("to_pre_conn", 32'(connected), 0);
      n = npoll;
      pad.joy_strb = 1'b1;
      wait_n(20);
      pad.joy_strb = 1'b0;
      for (int w = 0; w < 50 && npoll == n; w++) tick();
      chk("to_poll_seen", npoll - n, 1);
      tick();
      chk("to_reconn", 32'(connected), 1);
      for (int w = 0; w < 3000 && connected === 1'b1; w++) tick();
      chk("to_dropped", 32'(connected), 0);
      chk("to_delay", cyc - poll_cyc, TIMEOUT);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
